// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock, 32 steps per operation.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause,
   input  logic [2:0]       ctl,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               div_q, div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;

   logic               is_signed, is_div, start;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] acc_step, prod_fix;

   assign is_signed = (ctl == OP_MULT) || (ctl == OP_DIV);
   assign is_div    = (ctl == OP_DIV) || (ctl == OP_DIVU);
   assign start     = (state_q == S_IDLE) && !pause &&
                      (ctl == OP_MULT || ctl == OP_MULTU || ctl == OP_DIV || ctl == OP_DIVU);
   assign rs_mag    = (is_signed && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
   assign rt_mag    = (is_signed && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;

   // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

   always_comb begin
      if (div_q) begin
         if (!div_trial[WIDTH])
            acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   assign prod_fix = neg_lo_q ? (~acc_step + 1'b1) : acc_step;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      b_d      = b_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (state_q == S_IDLE) begin
         if (start) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            busy_d   = 1'b1;
            div_d    = is_div;
            acc_d    = {{WIDTH{1'b0}}, (is_div ? rs_mag : rt_mag)};
            b_d      = is_div ? rt_mag : rs_mag;
            // A zero divisor must leave the all-ones quotient un-negated.
            neg_lo_d = is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]) && !(is_div && rt == '0);
            neg_hi_d = is_signed && is_div && rs[WIDTH-1];
         end else if (!pause && ctl == OP_MTHI) begin
            hi_d = rs;
         end else if (!pause && ctl == OP_MTLO) begin
            lo_d = rs;
         end
      end else begin
         acc_d = acc_step;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (div_q) begin
               lo_d = neg_lo_q ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
               hi_d = neg_hi_q ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1) : acc_step[2*WIDTH-1:WIDTH];
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pause = 1'b0;
   logic [2:0]  ctl = 3'd0;
   logic [31:0] rs = '0;
   logic [31:0] rt = '0;
   logic        busy;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] sb_q[$];
   logic [63:0] last_exp = '0;

   muldiv_seq dut (
      .clk(clk), .rst(rst), .pause(pause), .ctl(ctl),
      .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic signed [31:0] sq, sr;
      case (op)
         3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         3'd2: p = {32'b0, a} * {32'b0, b};
         3'd3: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
            else begin
               sq = $signed(a) / $signed(b);
               sr = $signed(a) % $signed(b);
               p = {sr, sq};
            end
         end
         3'd4: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         default: p = '0;
      endcase
      return p;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int cnt;
      logic [63:0] exp;
      sb_q.push_back(model(op, a, b));
      @(negedge clk);
      ctl = op; rs = a; rt = b;
      @(negedge clk);
      ctl = 3'd0;
      vectors++;
      if ({hi, lo} !== last_exp) begin
         miscompares++;
         $display("FAIL e0_hold op=%0d got %h expected %h", op, {hi, lo}, last_exp);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt != 32) begin
         miscompares++;
         $display("FAIL busy_len op=%0d got %0d expected 32", op, cnt);
      end
      exp = sb_q.pop_front();
      last_exp = exp;
      vectors++;
      if ({hi, lo} !== exp) begin
         miscompares++;
         $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h expected hi=%h lo=%h",
                  op, a, b, hi, lo, exp[63:32], exp[31:0]);
      end
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL reset got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mul();
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(3'd1, 32'hFFFFFFFD, 32'h00000007);
      run_op(3'd1, 32'h80000000, 32'h80000000);
      run_op(3'd1, 32'h7FFFFFFF, 32'h80000000);
      for (int i = 0; i < 4; i++) begin
         run_op(3'd1, $urandom, $urandom);
         run_op(3'd2, $urandom, $urandom);
      end
   endtask

   task automatic test_div();
      run_op(3'd3, 32'hFFFFFFF9, 32'h00000002);
      run_op(3'd4, 32'hFFFFFFF9, 32'h00000002);
      run_op(3'd3, 32'h00000007, 32'hFFFFFFFE);
      run_op(3'd4, 32'h12345678, 32'h00000000);
      run_op(3'd3, 32'hFFFFFF00, 32'h00000000);
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) begin
         run_op(3'd3, $urandom, $urandom_range(1, 32'hFFFF));
         run_op(3'd4, $urandom, $urandom);
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [63:0] exp;
      int seen_busy = 0;
      @(negedge clk);
      ctl = 3'd5; rs = 32'hA5A5A5A5;
      @(negedge clk);
      seen_busy += busy;
      ctl = 3'd6; rs = 32'h5A5A5A5A;
      @(negedge clk);
      seen_busy += busy;
      ctl = 3'd0;
      @(negedge clk);
      seen_busy += busy;
      last_exp = {32'hA5A5A5A5, 32'h5A5A5A5A};
      vectors++;
      if ({hi, lo} !== last_exp || seen_busy != 0) begin
         miscompares++;
         $display("FAIL mthi_mtlo got hi=%h lo=%h busy_seen=%0d expected hi=a5a5a5a5 lo=5a5a5a5a busy_seen=0",
                  hi, lo, seen_busy);
      end
      // MTLO issued mid-multiply must be dropped.
      sb_q.push_back(model(3'd1, 32'h00012345, 32'hFFFF0003));
      ctl = 3'd1; rs = 32'h00012345; rt = 32'hFFFF0003;
      @(negedge clk);
      ctl = 3'd0;
      repeat (9) @(negedge clk);
      ctl = 3'd6; rs = 32'hDEADBEEF;
      @(negedge clk);
      ctl = 3'd5;
      @(negedge clk);
      ctl = 3'd0;
      repeat (30) @(negedge clk);
      exp = sb_q.pop_front();
      last_exp = exp;
      vectors++;
      if ({hi, lo} !== exp || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mtlo_while_busy got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
                  hi, lo, busy, exp[63:32], exp[31:0]);
      end
   endtask

   task automatic test_async_reset();
      ctl = 3'd4; rs = 32'hFFFFFFFF; rt = 32'h00000003;
      @(negedge clk);
      ctl = 3'd0;
      repeat (14) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_busy got %b expected 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
      @(negedge clk);
      rst = 1'b0;
      last_exp = '0;
      pause = 1'b1;
      ctl = 3'd1; rs = 32'h00000005; rt = 32'h00000006;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL pause_block got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
      pause = 1'b0;
      ctl = 3'd0;
      run_op(3'd1, 32'h00000005, 32'h00000006);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_mthi_mtlo();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
